// File: rtl/uart_pkg.sv
// Shared types, constants and divider helper for the uart block.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int DATA_BITS = 8;

   function automatic int calc_div(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; o_tc is high during the last cycle of a loaded period.
module uart_bit_timer #(
   parameter int W = 9
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;
   logic         r_run;

   // Loading N-1 yields a terminal pulse N cycles later; reloading on that pulse keeps periods exact.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= {W{1'b0}};
         r_run <= 1'b0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
         r_run <= 1'b1;
      end else if (r_run) begin
         if (r_cnt == {W{1'b0}}) begin
            r_run <= 1'b0;
         end else begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign o_tc = r_run && (r_cnt == {W{1'b0}});

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART with integer baud divider.
// Define UART_RX_FRAME_ERR_EN to add the o_rx_frame_err pulse output.
module uart
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic                 o_tx,
   output logic                 o_rx_valid,
   output logic [DATA_BITS-1:0] o_rx_data,
   input  logic [DATA_BITS-1:0] i_tx_data,
   input  logic                 i_tx_start,
   output logic                 o_tx_busy
`ifdef UART_RX_FRAME_ERR_EN
   ,
   output logic                 o_rx_frame_err
`endif
);

   localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);
   localparam int TW  = $clog2(DIV);
   localparam logic [TW-1:0] FULL_BIT = TW'(DIV - 1);
   localparam logic [TW-1:0] HALF_BIT = TW'(DIV / 2 - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   uart_state_e          r_tx_state, w_tx_state_nxt;
   logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
   logic [2:0]           r_tx_bit, w_tx_bit_nxt;
   logic                 r_tx, w_tx_nxt, r_tx_busy, w_tx_busy_nxt;
   logic                 w_tx_load, w_tx_tc;

   uart_state_e          r_rx_state, w_rx_state_nxt;
   logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt, r_rx_data, w_rx_data_nxt;
   logic [2:0]           r_rx_bit, w_rx_bit_nxt;
   logic                 r_rx_valid, w_rx_valid_nxt;
   logic                 r_rx_meta, r_rx_sync, r_rx_prev;
   logic                 w_rx_load, w_rx_tc;
   logic [TW-1:0]        w_rx_load_val;
`ifdef UART_RX_FRAME_ERR_EN
   logic                 r_rx_ferr, w_rx_ferr_nxt;
`endif

   uart_bit_timer #(.W(TW)) u_tx_timer (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(w_tx_load),
      .i_load_val(FULL_BIT), .o_tc(w_tx_tc)
   );

   uart_bit_timer #(.W(TW)) u_rx_timer (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(w_rx_load),
      .i_load_val(w_rx_load_val), .o_tc(w_rx_tc)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_state <= IDLE;
         r_tx_shift <= {DATA_BITS{1'b0}};
         r_tx_bit   <= 3'd0;
         r_tx       <= 1'b1;
         r_tx_busy  <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx       <= w_tx_nxt;
         r_tx_busy  <= w_tx_busy_nxt;
      end
   end

   // The line level is registered, so each bit value is chosen one cycle before it appears.
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_nxt       = r_tx;
      w_tx_busy_nxt  = r_tx_busy;
      w_tx_load      = 1'b0;
      case (r_tx_state)
         IDLE: begin
            if (i_tx_start) begin
               w_tx_state_nxt = START;
               w_tx_shift_nxt = i_tx_data;
               w_tx_nxt       = 1'b0;
               w_tx_busy_nxt  = 1'b1;
               w_tx_load      = 1'b1;
            end else begin
               w_tx_nxt      = 1'b1;
               w_tx_busy_nxt = 1'b0;
            end
         end
         START: begin
            if (w_tx_tc) begin
               w_tx_state_nxt = DATA;
               w_tx_nxt       = r_tx_shift[0];
               w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
               w_tx_bit_nxt   = 3'd0;
               w_tx_load      = 1'b1;
            end else begin
               w_tx_load = 1'b0;
            end
         end
         DATA: begin
            if (w_tx_tc) begin
               w_tx_load = 1'b1;
               if (r_tx_bit == LAST_BIT) begin
                  w_tx_state_nxt = STOP;
                  w_tx_nxt       = 1'b1;
               end else begin
                  w_tx_bit_nxt   = r_tx_bit + 3'd1;
                  w_tx_nxt       = r_tx_shift[0];
                  w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
               end
            end else begin
               w_tx_load = 1'b0;
            end
         end
         STOP: begin
            if (w_tx_tc) begin
               w_tx_state_nxt = IDLE;
               w_tx_busy_nxt  = 1'b0;
               w_tx_nxt       = 1'b1;
            end else begin
               w_tx_load = 1'b0;
            end
         end
         default: begin
            w_tx_state_nxt = IDLE;
            w_tx_nxt       = 1'b1;
            w_tx_busy_nxt  = 1'b0;
         end
      endcase
   end

   // r_rx_prev makes IDLE wait for the line to return high before another start is seen.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= IDLE;
         r_rx_shift <= {DATA_BITS{1'b0}};
         r_rx_bit   <= 3'd0;
         r_rx_data  <= {DATA_BITS{1'b0}};
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_meta  <= i_rx;
         r_rx_sync  <= r_rx_meta;
         r_rx_prev  <= r_rx_sync;
         r_rx_state <= w_rx_state_nxt;
         r_rx_shift <= w_rx_shift_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_valid <= w_rx_valid_nxt;
      end
   end

`ifdef UART_RX_FRAME_ERR_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_ferr <= 1'b0;
      end else begin
         r_rx_ferr <= w_rx_ferr_nxt;
      end
   end
   assign o_rx_frame_err = r_rx_ferr;
`endif

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = 1'b0;
      w_rx_load      = 1'b0;
      w_rx_load_val  = FULL_BIT;
`ifdef UART_RX_FRAME_ERR_EN
      w_rx_ferr_nxt  = 1'b0;
`endif
      case (r_rx_state)
         IDLE: begin
            if (r_rx_prev && !r_rx_sync) begin
               w_rx_state_nxt = START;
               w_rx_load      = 1'b1;
               w_rx_load_val  = HALF_BIT;
            end else begin
               w_rx_load = 1'b0;
            end
         end
         START: begin
            if (w_rx_tc) begin
               if (!r_rx_sync) begin
                  w_rx_state_nxt = DATA;
                  w_rx_bit_nxt   = 3'd0;
                  w_rx_load      = 1'b1;
               end else begin
                  w_rx_state_nxt = IDLE;
               end
            end else begin
               w_rx_load = 1'b0;
            end
         end
         DATA: begin
            if (w_rx_tc) begin
               w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
               w_rx_load      = 1'b1;
               if (r_rx_bit == LAST_BIT) begin
                  w_rx_state_nxt = STOP;
               end else begin
                  w_rx_bit_nxt = r_rx_bit + 3'd1;
               end
            end else begin
               w_rx_load = 1'b0;
            end
         end
         STOP: begin
            if (w_rx_tc) begin
               w_rx_state_nxt = IDLE;
               if (r_rx_sync) begin
                  w_rx_data_nxt  = r_rx_shift;
                  w_rx_valid_nxt = 1'b1;
               end else begin
`ifdef UART_RX_FRAME_ERR_EN
                  w_rx_ferr_nxt  = 1'b1;
`else
                  w_rx_valid_nxt = 1'b0;
`endif
               end
            end else begin
               w_rx_load = 1'b0;
            end
         end
         default: begin
            w_rx_state_nxt = IDLE;
         end
      endcase
   end

   assign o_tx       = r_tx;
   assign o_tx_busy  = r_tx_busy;
   assign o_rx_valid = r_rx_valid;
   assign o_rx_data  = r_rx_data;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: random bytes against a serial-line reference model.
module tb_uart;

   localparam int CLK_HALF = 10;
   localparam int BIT_T    = 8680;
   localparam int DIV      = 434;

   logic       clk, rst_n, rx_drv, loop_en, tx_start;
   logic       tx, tx_busy, rx_valid, dut_rx;
   logic [7:0] rx_data, tx_data;
`ifdef UART_RX_FRAME_ERR_EN
   logic       ferr;
   int         ferr_cnt = 0;
   int         ferr_base;
`endif

   int          n_cmp, n_mis;
   logic [7:0]  rxq[$];
   longint      rxt[$];
   logic [7:0]  txq[$];
   logic [7:0]  exp_b, last_good, mon_b;
   longint      t0, lat;

   assign dut_rx = loop_en ? tx : rx_drv;

   uart dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(dut_rx), .o_tx(tx),
      .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_tx_data(tx_data),
      .i_tx_start(tx_start), .o_tx_busy(tx_busy)
`ifdef UART_RX_FRAME_ERR_EN
      , .o_rx_frame_err(ferr)
`endif
   );

   initial clk = 1'b0;
   always #CLK_HALF clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid) begin
         rxq.push_back(rx_data);
         rxt.push_back($time);
      end
   end

`ifdef UART_RX_FRAME_ERR_EN
   always @(negedge clk) if (ferr) ferr_cnt++;
`endif

   // Serial monitor on tx: decode mid-bit like an ideal receiver.
   initial begin
      forever begin
         @(negedge tx);
         #(BIT_T / 2);
         if (tx == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               #(BIT_T);
               mon_b[i] = tx;
            end
            #(BIT_T);
            check("tx_stop_bit", {31'd0, tx}, 32'd1);
            txq.push_back(mon_b);
         end
      end
   end

   task automatic send_rx(input logic [7:0] b, input logic stop_bit, output longint ts);
      rx_drv = 1'b0;
      ts = $time;
      #(BIT_T);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         #(BIT_T);
      end
      rx_drv = stop_bit;
      #(BIT_T);
      rx_drv = 1'b1;
      #(2 * BIT_T);
   endtask

   task automatic wait_busy_low(input string tag);
      int c;
      c = 0;
      while (tx_busy && c < 6000) begin
         @(posedge clk); #1;
         c++;
      end
      check(tag, {31'd0, tx_busy}, 32'd0);
   endtask

   task automatic tx_frame(input logic [7:0] b, input logic poke);
      int c, cnt;
      @(negedge clk);
      tx_data  = b;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      cnt = tx_busy ? 1 : 0;
      c = 0;
      while (tx_busy && c < 6000) begin
         if (poke && c == 2000) begin
            tx_data  = 8'h3C;
            tx_start = 1'b1;
         end else if (poke && c == 2001) begin
            tx_start = 1'b0;
         end
         @(posedge clk); #1;
         if (tx_busy) cnt++;
         c++;
      end
      check("tx_busy_len", cnt, 10 * DIV);
      check("tx_frames", txq.size(), 1);
      check("tx_byte", (txq.size() > 0) ? {24'd0, txq.pop_front()} : 32'h1FF, {24'd0, b});
      repeat (10) @(posedge clk);
      #1;
      check("tx_not_queued", {31'd0, tx_busy}, 32'd0);
      check("tx_idle_high", {31'd0, tx}, 32'd1);
      txq.delete();
   endtask

   initial begin
      #(3_000_000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_mis = 0;
      rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
      tx_start = 1'b0; tx_data = 8'h00;
      #90;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_data", {24'd0, rx_data}, 32'd0);
      #10;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      for (int k = 0; k < 3; k++) begin
         exp_b = (k == 0) ? 8'h5A : 8'($urandom_range(0, 255));
         rxq.delete(); rxt.delete();
         send_rx(exp_b, 1'b1, t0);
         check("rx_pulses", rxq.size(), 1);
         check("rx_byte", (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'h1FF, {24'd0, exp_b});
         lat = (rxt.size() > 0) ? (rxt[0] - t0) : 0;
         check("rx_latency", {31'd0, (lat >= 9 * BIT_T && lat <= 10 * BIT_T)}, 32'd1);
         last_good = exp_b;
      end
      repeat (2000) @(posedge clk);
      #1;
      check("rx_hold", {24'd0, rx_data}, {24'd0, last_good});

      txq.delete();
      tx_frame(8'hA5, 1'b1);
      tx_frame(8'($urandom_range(0, 255)), 1'b0);

`ifdef UART_RX_FRAME_ERR_EN
      ferr_base = ferr_cnt;
`endif
      rxq.delete();
      send_rx(8'h81, 1'b0, t0);
      check("ferr_no_valid", rxq.size(), 0);
      check("ferr_data_kept", {24'd0, rx_data}, {24'd0, last_good});
`ifdef UART_RX_FRAME_ERR_EN
      check("ferr_pulse", ferr_cnt - ferr_base, 1);
      ferr_base = ferr_cnt;
`endif

      rxq.delete();
      rx_drv = 1'b0;
      #(BIT_T / 4);
      rx_drv = 1'b1;
      #(2 * BIT_T);
      check("glitch_no_valid", rxq.size(), 0);
      check("glitch_data_kept", {24'd0, rx_data}, {24'd0, last_good});
`ifdef UART_RX_FRAME_ERR_EN
      check("glitch_no_ferr", ferr_cnt - ferr_base, 0);
`endif

      txq.delete(); rxq.delete();
      loop_en = 1'b1;
      @(negedge clk);
      tx_data  = 8'h00;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_data = 8'hFF;
      wait_busy_low("lb_end0");
      @(posedge clk); #1;
      check("lb_b2b_1", {31'd0, tx_busy}, 32'd1);
      tx_data = 8'h55;
      wait_busy_low("lb_end1");
      @(posedge clk); #1;
      check("lb_b2b_2", {31'd0, tx_busy}, 32'd1);
      tx_start = 1'b0;
      wait_busy_low("lb_end2");
      repeat (100) @(posedge clk);
      #1;
      check("lb_pulses", rxq.size(), 3);
      check("lb_rx0", (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'h1FF, 32'h00);
      check("lb_rx1", (rxq.size() > 1) ? {24'd0, rxq[1]} : 32'h1FF, 32'hFF);
      check("lb_rx2", (rxq.size() > 2) ? {24'd0, rxq[2]} : 32'h1FF, 32'h55);
      check("lb_tx_frames", txq.size(), 3);
      check("lb_rx_data", {24'd0, rx_data}, 32'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
